// File: rtl/root_arb_pkg.sv
// Shared types and widths for the root job arbiter.
// Optional watchdog in root_job_arbiter is enabled with ROOT_ARB_TIMEOUT_EN.
package root_arb_pkg;

    localparam int unsigned RAD_W = 10;
    localparam int unsigned EXP_W = 3;
    localparam int unsigned RES_W = 20;

    localparam logic [RES_W-1:0] ERR_DATA = 20'hFFFFF;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StResp,
        StGuard
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter_ptr.sv
// Pointer-based round-robin arbiter: first asserted request at or after the
// pointer wins; the pointer moves past the winner when the grant is taken.
module rr_arbiter_ptr #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic             advance,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    localparam logic [IDX_W:0] NREQ_W = (IDX_W + 1)'(NREQ);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W:0]   cand;
    logic [IDX_W:0]   ptr_inc;

    // Extra bit on cand keeps ptr + offset from overflowing before the wrap.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        cand    = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand = {1'b0, ptr_q} + (IDX_W + 1)'(off);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!gnt_any && req[cand[IDX_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[IDX_W-1:0];
            end
        end
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        ptr_inc = {1'b0, gnt_idx} + 1'b1;
        if (advance && gnt_any) begin
            ptr_d = (ptr_inc >= NREQ_W) ? '0 : ptr_inc[IDX_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/root_job_arbiter.sv
// Shares one iterative Root datapath between NREQ requesters, one job at a time.
// Define ROOT_ARB_TIMEOUT_EN to add a WAIT watchdog that aborts a stuck datapath.
module root_job_arbiter
    import root_arb_pkg::*;
#(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned ISSUE_CYC   = 2,
    parameter int unsigned GUARD_CYC   = 2,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*RAD_W-1:0] req_data_1,
    input  logic [NREQ*EXP_W-1:0] req_data_2,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [RES_W-1:0]      rsp_data,
    output logic                  rsp_err,
    output logic                  root_in_valid,
    output logic [RAD_W-1:0]      root_in_data_1,
    output logic [EXP_W-1:0]      root_in_data_2,
    input  logic                  root_out_valid,
    input  logic [RES_W-1:0]      root_out_data,
    output logic                  root_rst_n,
    output logic                  busy
);

    localparam int unsigned IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_MAX = (ISSUE_CYC > GUARD_CYC) ? ISSUE_CYC : GUARD_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CNT_W-1:0] ISSUE_LAST = CNT_W'(ISSUE_CYC - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] gnt_q, gnt_d;
    logic [RAD_W-1:0] rad_q, rad_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [RES_W-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic             zero_job_q, zero_job_d;

    logic [NREQ-1:0]  arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;
    logic             arb_advance;
    logic [RAD_W-1:0] sel_rad;
    logic [EXP_W-1:0] sel_exp;
    logic             abort_pulse;

`ifdef ROOT_ARB_TIMEOUT_EN
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] wdog_q, wdog_d;
    logic [1:0]  abort_q, abort_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

    rr_arbiter_ptr #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (arb_advance),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    always_comb begin
        sel_rad = '0;
        sel_exp = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                sel_rad = req_data_1[i*RAD_W +: RAD_W];
                sel_exp = req_data_2[i*EXP_W +: EXP_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        rad_d       = rad_q;
        exp_d       = exp_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        zero_job_d  = zero_job_q;
        arb_advance = 1'b0;
`ifdef ROOT_ARB_TIMEOUT_EN
        wdog_d  = '0;
        abort_d = (abort_q != '0) ? abort_q - 1'b1 : '0;
`endif
        unique case (state_q)
            StIdle: begin
                if (arb_any) begin
                    arb_advance = 1'b1;
                    gnt_d       = arb_idx;
                    rad_d       = sel_rad;
                    exp_d       = sel_exp;
                    cnt_d       = '0;
                    // A zero exponent has no defined root: answer with an error, skip the datapath.
                    if (sel_exp == '0) begin
                        zero_job_d = 1'b1;
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                        state_d    = StResp;
                    end else begin
                        zero_job_d = 1'b0;
                        state_d    = StIssue;
                    end
                end
            end
            StIssue: begin
                if (cnt_q == ISSUE_LAST) begin
                    cnt_d   = '0;
                    state_d = StWait;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWait: begin
                if (root_out_valid) begin
                    rsp_data_d = root_out_data;
                    rsp_err_d  = 1'b0;
                    state_d    = StResp;
`ifdef ROOT_ARB_TIMEOUT_EN
                end else if (wdog_q == WDOG_LAST) begin
                    abort_d    = 2'd2;
                    rsp_data_d = ERR_DATA;
                    rsp_err_d  = 1'b1;
                    state_d    = StResp;
                end else begin
                    wdog_d = wdog_q + 16'd1;
`endif
                end
            end
            StResp: begin
                if (rsp_ready[gnt_q]) begin
                    cnt_d   = '0;
                    state_d = zero_job_q ? StIdle : StGuard;
                end
            end
            StGuard: begin
                if (cnt_q == GUARD_LAST) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            gnt_q      <= '0;
            rad_q      <= '0;
            exp_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            zero_job_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            rad_q      <= rad_d;
            exp_q      <= exp_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            zero_job_q <= zero_job_d;
        end
    end

`ifdef ROOT_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q  <= '0;
            abort_q <= '0;
        end else begin
            wdog_q  <= wdog_d;
            abort_q <= abort_d;
        end
    end

    // Registered so the datapath reset is glitch-free.
    assign abort_pulse = (abort_q != '0);
`else
    assign abort_pulse = 1'b0;
`endif

    always_comb begin
        rsp_valid = '0;
        if (state_q == StResp) begin
            rsp_valid[gnt_q] = 1'b1;
        end
    end

    assign req_ready      = (state_q == StIdle) ? arb_gnt : '0;
    assign rsp_data       = rsp_data_q;
    assign rsp_err        = rsp_err_q;
    assign root_in_valid  = (state_q == StIssue);
    assign root_in_data_1 = rad_q;
    assign root_in_data_2 = exp_q;
    assign root_rst_n     = rst_n & ~abort_pulse;
    assign busy           = (state_q != StIdle);

endmodule
